// File: rtl/aq_mp_clk_ratio_gen_pkg.sv
// Shared definitions for the clock-ratio generator slice.
//  DIVW_DEF      default ratio field width
//  RST_RATIO_DEF ratio every channel comes out of reset with (1 = divide by 2)
//  ch_st_e       per-channel ratio-change handshake state
package aq_mp_clk_ratio_gen_pkg;
  localparam int DIVW_DEF      = 4;
  localparam int RST_RATIO_DEF = 1;

  typedef enum logic {
    CH_IDLE = 1'b0,  // no change outstanding
    CH_PEND = 1'b1   // ratio captured, waiting for the next wrap (or disable)
  } ch_st_e;
endpackage

// File: rtl/aq_mp_clk_ratio_gen_if.sv
// Per-channel control/status bundle of the clock-ratio generator.
//  master: software/config side (drives ch_en, cfg_req, cfg_ratio)
//  slave : generator side (drives cfg_busy, cfg_ack, clk_en, clk_out)
interface aq_mp_clk_ratio_gen_if #(
  parameter int NCH  = 2,
  parameter int DIVW = aq_mp_clk_ratio_gen_pkg::DIVW_DEF
);
  logic [NCH-1:0]           ch_en;
  logic [NCH-1:0]           cfg_req;
  logic [NCH-1:0][DIVW-1:0] cfg_ratio;
  logic [NCH-1:0]           cfg_busy;
  logic [NCH-1:0]           cfg_ack;
  logic [NCH-1:0]           clk_en;
  logic [NCH-1:0]           clk_out;

  modport master (
    output ch_en, cfg_req, cfg_ratio,
    input  cfg_busy, cfg_ack, clk_en, clk_out
  );
  modport slave (
    input  ch_en, cfg_req, cfg_ratio,
    output cfg_busy, cfg_ack, clk_en, clk_out
  );
endinterface

// File: rtl/aq_mp_clk_ratio_gen_ch.sv
// One divided-clock channel: wrap counter, pending-ratio register with
// req/ack handshake, registered enable pulse and gated clock.
//  ch_en     run enable; low holds the counter at 0 and the enable low
//  cfg_req   capture cfg_ratio when idle; ignored while a change is pending
//  cfg_busy  change pending;  cfg_ack  one-cycle pulse when it applies
//  clk_en_f  registered enable, one high cycle per ratio+1 cycles
//  clk_out   forever_cpuclk gated by clk_en_f
module aq_mp_clk_ratio_gen_ch
  import aq_mp_clk_ratio_gen_pkg::*;
#(
  parameter int DIVW      = DIVW_DEF,
  parameter int RST_RATIO = RST_RATIO_DEF
) (
  input  logic            forever_cpuclk,
  input  logic            clkgen_rst_b,
  input  logic            ch_en,
  input  logic            cfg_req,
  input  logic [DIVW-1:0] cfg_ratio,
  output logic            cfg_busy,
  output logic            cfg_ack,
  output logic            clk_en_f,
  output logic            clk_out
);
  ch_st_e          st_q, st_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] ratio_cur_q, ratio_cur_d;
  logic [DIVW-1:0] ratio_pend_q, ratio_pend_d;
  logic            en_f_q, en_f_d;
  logic            ack_q, ack_d;
  logic            gate_q, gate_d;
  logic            wrap, apply;

  always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
    if (!clkgen_rst_b) begin
      st_q         <= CH_IDLE;
      cnt_q        <= '0;
      ratio_cur_q  <= DIVW'(RST_RATIO);
      ratio_pend_q <= DIVW'(RST_RATIO);
      en_f_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      ratio_cur_q  <= ratio_cur_d;
      ratio_pend_q <= ratio_pend_d;
      en_f_q       <= en_f_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    ratio_pend_d = ratio_pend_q;
    wrap         = (cnt_q == ratio_cur_q);
    // A pending change lands on a wrap, or at once when the channel is stopped
    // (there is no running period to keep glitch-free).
    apply        = (st_q == CH_PEND) && (wrap || !ch_en);
    cnt_d        = (!ch_en || wrap) ? '0 : cnt_q + 1'b1;
    en_f_d       = ch_en && wrap;
    ratio_cur_d  = apply ? ratio_pend_q : ratio_cur_q;
    ack_d        = apply;
    case (st_q)
      CH_IDLE: if (cfg_req) begin
        ratio_pend_d = cfg_ratio;
        st_d         = CH_PEND;
      end
      CH_PEND: if (apply) st_d = CH_IDLE;
      default: st_d = CH_IDLE;
    endcase
  end

  // Gate enable retimed on the falling edge, so it only changes while the
  // clock is low and clk_out never carries a runt pulse.
  always_comb gate_d = en_f_q;

  always_ff @(negedge forever_cpuclk or negedge clkgen_rst_b) begin
    if (!clkgen_rst_b) gate_q <= 1'b0;
    else               gate_q <= gate_d;
  end

  assign clk_out  = forever_cpuclk & gate_q;
  assign clk_en_f = en_f_q;
  assign cfg_busy = (st_q == CH_PEND);
  assign cfg_ack  = ack_q;
endmodule

// File: rtl/aq_mp_clk_ratio_gen.sv
// Multi-channel programmable clock-enable generator.
//  forever_cpuclk/clkgen_rst_b  core clock, async active-low reset
//  pad_yy_scan_mode             forces every clk_en high (gated clocks unaffected)
//  bus                          per-channel enable/config/status/outputs
//  sync_en_i -> sync_en_f       external bus enables retimed by one cycle
module aq_mp_clk_ratio_gen
  import aq_mp_clk_ratio_gen_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int DIVW      = DIVW_DEF,
  parameter int RST_RATIO = RST_RATIO_DEF,
  parameter int NSYNC     = 1
) (
  input  logic             forever_cpuclk,
  input  logic             clkgen_rst_b,
  input  logic             pad_yy_scan_mode,
  aq_mp_clk_ratio_gen_if.slave bus,
  input  logic [NSYNC-1:0] sync_en_i,
  output logic [NSYNC-1:0] sync_en_f
);
  logic [NCH-1:0]   clk_en_f, busy_w, ack_w, clk_out_w;
  logic [NSYNC-1:0] sync_en_q, sync_en_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    aq_mp_clk_ratio_gen_ch #(.DIVW(DIVW), .RST_RATIO(RST_RATIO)) u_ch (
      .forever_cpuclk (forever_cpuclk),
      .clkgen_rst_b   (clkgen_rst_b),
      .ch_en          (bus.ch_en[g]),
      .cfg_req        (bus.cfg_req[g]),
      .cfg_ratio      (bus.cfg_ratio[g]),
      .cfg_busy       (busy_w[g]),
      .cfg_ack        (ack_w[g]),
      .clk_en_f       (clk_en_f[g]),
      .clk_out        (clk_out_w[g])
    );
  end

  assign bus.cfg_busy = busy_w;
  assign bus.cfg_ack  = ack_w;
  assign bus.clk_out  = clk_out_w;
  assign bus.clk_en   = pad_yy_scan_mode ? '1 : clk_en_f;

  always_comb sync_en_d = sync_en_i;

  always_ff @(posedge forever_cpuclk or negedge clkgen_rst_b) begin
    if (!clkgen_rst_b) sync_en_q <= '0;
    else               sync_en_q <= sync_en_d;
  end

  assign sync_en_f = sync_en_q;
endmodule

// File: tb/tb_aq_mp_clk_ratio_gen.sv
module tb_aq_mp_clk_ratio_gen;
  localparam int NCH = 2, DIVW = 4, NSYNC = 1;

  logic forever_cpuclk = 1'b0;
  logic clkgen_rst_b   = 1'b1;
  logic pad_yy_scan_mode;
  logic [NSYNC-1:0] sync_en_i, sync_en_f;

  aq_mp_clk_ratio_gen_if #(.NCH(NCH), .DIVW(DIVW)) bus ();

  aq_mp_clk_ratio_gen #(.NCH(NCH), .DIVW(DIVW), .RST_RATIO(1), .NSYNC(NSYNC)) dut (
    .forever_cpuclk   (forever_cpuclk),
    .clkgen_rst_b     (clkgen_rst_b),
    .pad_yy_scan_mode (pad_yy_scan_mode),
    .bus              (bus),
    .sync_en_i        (sync_en_i),
    .sync_en_f        (sync_en_f)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  // One row = ch0 inputs held across an edge + ch0 outputs expected after it.
  typedef struct packed {
    logic            en;
    logic            req;
    logic [DIVW-1:0] ratio;
    logic            scan;
    logic            f;     // expected registered enable (BUFGCE CE)
    logic            busy;
    logic            ack;
  } row_t;

  row_t exp_q[$];
  logic sync_q[$];
  int   errs = 0, checks = 0;
  int   edge_n = 0;   // edges since reset release; ch1 stays at ratio 1
  logic prev_f = 1'b0;

  function automatic row_t mk(logic en, logic req, int ratio, logic scan,
                              logic f, logic busy, logic ack);
    row_t r;
    r.en = en; r.req = req; r.ratio = DIVW'(ratio); r.scan = scan;
    r.f = f; r.busy = busy; r.ack = ack;
    return r;
  endfunction

  task automatic drive(input row_t r);
    bus.ch_en[0]     = r.en;
    bus.cfg_req[0]   = r.req;
    bus.cfg_ratio[0] = r.ratio;
    pad_yy_scan_mode = r.scan;
    exp_q.push_back(r);
  endtask

  task automatic test_reset();
    bus.ch_en = '1; bus.cfg_req = '0; bus.cfg_ratio = '0;
    pad_yy_scan_mode = 1'b0; sync_en_i = '1;
    #1 clkgen_rst_b = 1'b0;
    repeat (3) @(negedge forever_cpuclk);
    checks++; if (bus.clk_en !== 2'b00) begin errs++; $display("FAIL rst_clk_en got %b want 00", bus.clk_en); end
    checks++; if (bus.cfg_busy !== 2'b00) begin errs++; $display("FAIL rst_busy got %b want 00", bus.cfg_busy); end
    checks++; if (bus.cfg_ack !== 2'b00) begin errs++; $display("FAIL rst_ack got %b want 00", bus.cfg_ack); end
    checks++; if (sync_en_f !== 1'b0) begin errs++; $display("FAIL rst_sync got %b want 0", sync_en_f); end
    pad_yy_scan_mode = 1'b1; #1;
    checks++; if (bus.clk_en !== 2'b11) begin errs++; $display("FAIL rst_scan_clk_en got %b want 11", bus.clk_en); end
    pad_yy_scan_mode = 1'b0; sync_en_i = '0;
    clkgen_rst_b = 1'b1; edge_n = 0; prev_f = 1'b0;
  endtask

  // Pattern checks live in each scenario: clk_out high phase, then ch0/ch1 status.
  task automatic test_div2_startup();
    row_t r[6];
    r = '{mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 0,0,0),
          mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0)};
    foreach (r[i]) begin
      row_t e; logic ee, e1;
      drive(r[i]);
      @(posedge forever_cpuclk); edge_n++; #1;
      checks++; if (bus.clk_out[0] !== prev_f) begin errs++; $display("FAIL div2 clk_out e%0d got %b want %b", edge_n, bus.clk_out[0], prev_f); end
      @(negedge forever_cpuclk);
      e = exp_q.pop_front(); ee = e.scan | e.f; e1 = e.scan | ~edge_n[0];
      checks++; if (bus.clk_en[0] !== ee) begin errs++; $display("FAIL div2 clk_en0 e%0d got %b want %b", edge_n, bus.clk_en[0], ee); end
      checks++; if (bus.clk_en[1] !== e1) begin errs++; $display("FAIL div2 clk_en1 e%0d got %b want %b", edge_n, bus.clk_en[1], e1); end
      checks++; if ({bus.cfg_busy[0], bus.cfg_ack[0]} !== {e.busy, e.ack}) begin errs++; $display("FAIL div2 busy/ack e%0d got %b%b want %b%b", edge_n, bus.cfg_busy[0], bus.cfg_ack[0], e.busy, e.ack); end
      prev_f = e.f;
    end
  endtask

  task automatic test_ratio_change();
    row_t r[10];
    r = '{mk(1,1,3,0, 0,1,0), mk(1,0,0,0, 1,0,1), mk(1,0,0,0, 0,0,0),
          mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0),
          mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0),
          mk(1,0,0,0, 1,0,0)};
    foreach (r[i]) begin
      row_t e; logic ee, e1;
      drive(r[i]);
      @(posedge forever_cpuclk); edge_n++; #1;
      checks++; if (bus.clk_out[0] !== prev_f) begin errs++; $display("FAIL chg clk_out e%0d got %b want %b", edge_n, bus.clk_out[0], prev_f); end
      @(negedge forever_cpuclk);
      e = exp_q.pop_front(); ee = e.scan | e.f; e1 = e.scan | ~edge_n[0];
      checks++; if (bus.clk_en[0] !== ee) begin errs++; $display("FAIL chg clk_en0 e%0d got %b want %b", edge_n, bus.clk_en[0], ee); end
      checks++; if (bus.clk_en[1] !== e1) begin errs++; $display("FAIL chg clk_en1 e%0d got %b want %b", edge_n, bus.clk_en[1], e1); end
      checks++; if ({bus.cfg_busy[0], bus.cfg_ack[0]} !== {e.busy, e.ack}) begin errs++; $display("FAIL chg busy/ack e%0d got %b%b want %b%b", edge_n, bus.cfg_busy[0], bus.cfg_ack[0], e.busy, e.ack); end
      prev_f = e.f;
    end
  endtask

  // Re-request 3 (equal to current) then 5 while busy: 5 must be dropped.
  task automatic test_req_while_busy();
    row_t r[12];
    r = '{mk(1,1,3,0, 0,1,0), mk(1,1,5,0, 0,1,0), mk(1,0,0,0, 0,1,0),
          mk(1,0,0,0, 1,0,1), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0),
          mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 0,0,0),
          mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0)};
    foreach (r[i]) begin
      row_t e; logic ee, e1;
      drive(r[i]);
      @(posedge forever_cpuclk); edge_n++; #1;
      checks++; if (bus.clk_out[0] !== prev_f) begin errs++; $display("FAIL busy clk_out e%0d got %b want %b", edge_n, bus.clk_out[0], prev_f); end
      @(negedge forever_cpuclk);
      e = exp_q.pop_front(); ee = e.scan | e.f; e1 = e.scan | ~edge_n[0];
      checks++; if (bus.clk_en[0] !== ee) begin errs++; $display("FAIL busy clk_en0 e%0d got %b want %b", edge_n, bus.clk_en[0], ee); end
      checks++; if (bus.clk_en[1] !== e1) begin errs++; $display("FAIL busy clk_en1 e%0d got %b want %b", edge_n, bus.clk_en[1], e1); end
      checks++; if ({bus.cfg_busy[0], bus.cfg_ack[0]} !== {e.busy, e.ack}) begin errs++; $display("FAIL busy busy/ack e%0d got %b%b want %b%b", edge_n, bus.cfg_busy[0], bus.cfg_ack[0], e.busy, e.ack); end
      prev_f = e.f;
    end
  endtask

  // Request on a wrap (captured only), ratio 0, then disable with a change pending.
  task automatic test_ratio0_disable();
    row_t r[19];
    r = '{mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0),
          mk(1,1,0,0, 1,1,0), mk(1,0,0,0, 0,1,0), mk(1,0,0,0, 0,1,0),
          mk(1,0,0,0, 0,1,0), mk(1,0,0,0, 1,0,1), mk(1,0,0,0, 1,0,0),
          mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 1,0,0),
          mk(1,1,2,0, 1,1,0), mk(0,0,0,0, 0,0,1), mk(0,0,0,0, 0,0,0),
          mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0),
          mk(1,0,0,0, 0,0,0)};
    foreach (r[i]) begin
      row_t e; logic ee, e1;
      drive(r[i]);
      @(posedge forever_cpuclk); edge_n++; #1;
      checks++; if (bus.clk_out[0] !== prev_f) begin errs++; $display("FAIL r0dis clk_out e%0d got %b want %b", edge_n, bus.clk_out[0], prev_f); end
      @(negedge forever_cpuclk);
      e = exp_q.pop_front(); ee = e.scan | e.f; e1 = e.scan | ~edge_n[0];
      checks++; if (bus.clk_en[0] !== ee) begin errs++; $display("FAIL r0dis clk_en0 e%0d got %b want %b", edge_n, bus.clk_en[0], ee); end
      checks++; if (bus.clk_en[1] !== e1) begin errs++; $display("FAIL r0dis clk_en1 e%0d got %b want %b", edge_n, bus.clk_en[1], e1); end
      checks++; if ({bus.cfg_busy[0], bus.cfg_ack[0]} !== {e.busy, e.ack}) begin errs++; $display("FAIL r0dis busy/ack e%0d got %b%b want %b%b", edge_n, bus.cfg_busy[0], bus.cfg_ack[0], e.busy, e.ack); end
      prev_f = e.f;
    end
  endtask

  // Scan forces clk_en high; the gated clock keeps the 1-in-4 cadence.
  task automatic test_scan();
    row_t r[11];
    r = '{mk(1,1,3,0, 0,1,0), mk(1,0,0,0, 1,0,1), mk(1,0,0,1, 0,0,0),
          mk(1,0,0,1, 0,0,0), mk(1,0,0,1, 0,0,0), mk(1,0,0,1, 1,0,0),
          mk(1,0,0,1, 0,0,0), mk(1,0,0,1, 0,0,0), mk(1,0,0,1, 0,0,0),
          mk(1,0,0,1, 1,0,0), mk(1,0,0,0, 0,0,0)};
    foreach (r[i]) begin
      row_t e; logic ee, e1;
      drive(r[i]);
      @(posedge forever_cpuclk); edge_n++; #1;
      checks++; if (bus.clk_out[0] !== prev_f) begin errs++; $display("FAIL scan clk_out e%0d got %b want %b", edge_n, bus.clk_out[0], prev_f); end
      @(negedge forever_cpuclk);
      e = exp_q.pop_front(); ee = e.scan | e.f; e1 = e.scan | ~edge_n[0];
      checks++; if (bus.clk_en[0] !== ee) begin errs++; $display("FAIL scan clk_en0 e%0d got %b want %b", edge_n, bus.clk_en[0], ee); end
      checks++; if (bus.clk_en[1] !== e1) begin errs++; $display("FAIL scan clk_en1 e%0d got %b want %b", edge_n, bus.clk_en[1], e1); end
      checks++; if ({bus.cfg_busy[0], bus.cfg_ack[0]} !== {e.busy, e.ack}) begin errs++; $display("FAIL scan busy/ack e%0d got %b%b want %b%b", edge_n, bus.cfg_busy[0], bus.cfg_ack[0], e.busy, e.ack); end
      prev_f = e.f;
    end
  endtask

  // Reset lands while ch0 holds a pending ratio 7: it must vanish without ack.
  task automatic test_async_reset();
    row_t r[5];
    row_t e;
    sync_en_i = 1'b1;
    drive(mk(1,1,7,0, 0,1,0));
    @(posedge forever_cpuclk); edge_n++;
    @(negedge forever_cpuclk);
    e = exp_q.pop_front();
    checks++; if (bus.cfg_busy[0] !== e.busy) begin errs++; $display("FAIL arst pre_busy got %b want %b", bus.cfg_busy[0], e.busy); end
    checks++; if (sync_en_f !== 1'b1) begin errs++; $display("FAIL arst pre_sync got %b want 1", sync_en_f); end
    bus.cfg_req[0] = 1'b0;
    #2 clkgen_rst_b = 1'b0;
    #1;
    checks++; if (bus.clk_en !== 2'b00) begin errs++; $display("FAIL arst clk_en got %b want 00", bus.clk_en); end
    checks++; if (bus.cfg_busy !== 2'b00) begin errs++; $display("FAIL arst busy got %b want 00", bus.cfg_busy); end
    checks++; if (bus.cfg_ack !== 2'b00) begin errs++; $display("FAIL arst ack got %b want 00", bus.cfg_ack); end
    checks++; if (sync_en_f !== 1'b0) begin errs++; $display("FAIL arst sync got %b want 0", sync_en_f); end
    @(posedge forever_cpuclk); #1;
    checks++; if (bus.clk_out !== 2'b00) begin errs++; $display("FAIL arst clk_out got %b want 00", bus.clk_out); end
    @(negedge forever_cpuclk);
    clkgen_rst_b = 1'b1; sync_en_i = 1'b0; edge_n = 0; prev_f = 1'b0;
    r = '{mk(1,0,0,0, 0,0,0), mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 0,0,0),
          mk(1,0,0,0, 1,0,0), mk(1,0,0,0, 0,0,0)};
    foreach (r[i]) begin
      logic ee, e1;
      drive(r[i]);
      @(posedge forever_cpuclk); edge_n++; #1;
      checks++; if (bus.clk_out[0] !== prev_f) begin errs++; $display("FAIL arst clk_out e%0d got %b want %b", edge_n, bus.clk_out[0], prev_f); end
      @(negedge forever_cpuclk);
      e = exp_q.pop_front(); ee = e.scan | e.f; e1 = e.scan | ~edge_n[0];
      checks++; if (bus.clk_en[0] !== ee) begin errs++; $display("FAIL arst clk_en0 e%0d got %b want %b", edge_n, bus.clk_en[0], ee); end
      checks++; if (bus.clk_en[1] !== e1) begin errs++; $display("FAIL arst clk_en1 e%0d got %b want %b", edge_n, bus.clk_en[1], e1); end
      checks++; if ({bus.cfg_busy[0], bus.cfg_ack[0]} !== {e.busy, e.ack}) begin errs++; $display("FAIL arst busy/ack e%0d got %b%b want %b%b", edge_n, bus.cfg_busy[0], bus.cfg_ack[0], e.busy, e.ack); end
      prev_f = e.f;
    end
  endtask

  task automatic test_sync_en();
    for (int i = 0; i < 16; i++) begin
      logic s, want;
      s = 1'($urandom_range(0, 1));
      sync_en_i = s;
      sync_q.push_back(s);
      @(posedge forever_cpuclk);
      @(negedge forever_cpuclk);
      want = sync_q.pop_front();
      checks++; if (sync_en_f !== want) begin errs++; $display("FAIL sync_en step%0d got %b want %b", i, sync_en_f, want); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_div2_startup();
    test_ratio_change();
    test_req_while_busy();
    test_ratio0_disable();
    test_scan();
    test_async_reset();
    test_sync_en();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
